mant_alu_seq: RTL and testbench

Parametrised, clocked sign-magnitude mantissa ALU for the floating-point datapath. Performs ADD, SUB and MUL on MW-bit unsigned magnitudes with separate sign bits, replacing the edge-triggered single-shot ALU with a valid/ready handshake unit. Sits between the exponent-align stage (which supplies aligned mantissas) and the normalise/round stage (which consumes magnitude, carry and sign). Multiply is an iterative shift-add producing the full 2*MW-bit product.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/mant_mul_iter.sv | 65 ++++++
 rtl/mant_alu_seq.sv | 163 ++++++++++++++++
 tb/tb_mant_alu_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: op encodings, ALU state enum and
// the default mantissa width.
package fp_pkg;

  localparam int MW_DEFAULT = 27;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
    S_DONE
  } state_e;

endpackage

// File: rtl/mant_mul_iter.sv
// Iterative shift-add multiplier core: one multiplier bit per cycle, MW cycles
// after start, then done pulses for one cycle with the full 2*MW-bit product.
module mant_mul_iter #(
  parameter int MW = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [MW-1:0]   mcand,
  input  logic [MW-1:0]   mplier,
  output logic            done,
  output logic [2*MW-1:0] prod
);

  localparam logic [MW-1:0] LAST = MW'(MW);

  // Upper half (with its carry bit) accumulates; lower half holds the
  // not-yet-consumed multiplier bits and collects product bits as it shifts.
  logic [2*MW:0] acc_q, acc_d;
  logic [MW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [MW:0]   upper_sum;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done    = busy_q && (cnt_q == LAST);

    upper_sum = acc_q[0] ? (acc_q[2*MW:MW] + {1'b0, mcand_q}) : acc_q[2*MW:MW];

    if (start) begin
      acc_d   = {(MW+1)'(0), mplier};
      mcand_d = mcand;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      acc_d = {upper_sum, acc_q[MW-1:0]} >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign prod = acc_q[2*MW-1:0];

endmodule

// File: rtl/mant_alu_seq.sv
// Sequential sign-magnitude mantissa ALU (ADD/SUB/MUL) with valid/ready handshakes.
// Define MANT_ALU_MUL_EN to build the iterative multiplier; otherwise op MUL reports op_err.
module mant_alu_seq
  import fp_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [MW-1:0] mag_a,
  input  logic          sign_a,
  input  logic [MW-1:0] mag_b,
  input  logic          sign_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] res_hi,
  output logic [MW-1:0] res_lo,
  output logic          carry,
  output logic          sign_r,
  output logic          op_err
);

`ifdef MANT_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [MW-1:0] a_q, a_d, b_q, b_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic          err_q, err_d;
  logic [MW-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          carry_q, carry_d, sign_q, sign_d, op_err_q, op_err_d;

  logic            accept, op_is_as, op_is_mul;
  logic            mul_done;
  logic [2*MW-1:0] mul_prod;
  logic [MW:0]     sum_w;
  logic [MW-1:0]   diff_w;
  logic            a_ge_b;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign op_is_as  = (op == OP_ADD) || (op == OP_SUB);
  assign op_is_mul = MUL_EN && (op == OP_MUL);

`ifdef MANT_ALU_MUL_EN
  mant_mul_iter #(.MW(MW)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && op_is_mul),
    .mcand  (mag_a),
    .mplier (mag_b),
    .done   (mul_done),
    .prod   (mul_prod)
  );
`else
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign a_ge_b = (a_q >= b_q);
  assign diff_w = a_ge_b ? (a_q - b_q) : (b_q - a_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    err_d    = err_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    carry_d  = carry_q;
    sign_d   = sign_q;
    op_err_d = op_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d   = mag_a;
          b_d   = mag_b;
          sa_d  = sign_a;
          sb_d  = (op == OP_SUB) ? ~sign_b : sign_b;
          // Rejected ops ride through ADDSUB so errors keep the ADD/SUB latency.
          err_d   = !(op_is_as || op_is_mul);
          state_d = op_is_mul ? S_MUL : S_ADDSUB;
        end
      end
      S_ADDSUB: begin
        state_d  = S_DONE;
        res_hi_d = '0;
        op_err_d = err_q;
        if (err_q) begin
          res_lo_d = '0;
          carry_d  = 1'b0;
          sign_d   = 1'b0;
        end else if (sa_q == sb_q) begin
          {carry_d, res_lo_d} = sum_w;
          sign_d = sa_q && (sum_w[MW-1:0] != '0);
        end else begin
          res_lo_d = diff_w;
          carry_d  = 1'b0;
          sign_d   = (a_ge_b ? sa_q : sb_q) && (diff_w != '0);
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d              = S_DONE;
          {res_hi_d, res_lo_d} = mul_prod;
          carry_d              = 1'b0;
          op_err_d             = 1'b0;
          sign_d               = (sa_q ^ sb_q) && (mul_prod != '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      err_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      err_q    <= err_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      op_err_q <= op_err_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign carry     = carry_q;
  assign sign_r    = sign_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_mant_alu_seq.sv
// Directed bench for mant_alu_seq (MW=27): vector table plus backpressure and
// mid-operation reset sequences; MUL expectations follow MANT_ALU_MUL_EN.
module tb_mant_alu_seq;
  import fp_pkg::*;

  localparam int MW   = 27;
  localparam int NVEC = 12;
`ifdef MANT_ALU_MUL_EN
  localparam int MUL_LAT = MW + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct {
    logic [1:0]      op;
    logic [MW-1:0]   a;
    logic            sa;
    logic [MW-1:0]   b;
    logic            sb;
    logic [2*MW-1:0] exp_prod;
    logic            exp_carry;
    logic            exp_sign;
    logic            exp_err;
    int              exp_lat;
  } vec_t;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    op;
  logic [MW-1:0] mag_a, mag_b, res_hi, res_lo;
  logic          sign_a, sign_b, carry, sign_r, op_err;

  int total = 0;
  int bad   = 0;
  vec_t vecs [NVEC];

  mant_alu_seq #(.MW(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .mag_a     (mag_a),
    .sign_a    (sign_a),
    .mag_b     (mag_b),
    .sign_b    (sign_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .carry     (carry),
    .sign_r    (sign_r),
    .op_err    (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one bundle, returns at the falling edge after the accepting edge with
  // operands scrambled so late input changes would corrupt a non-latching DUT.
  task automatic send(input logic [1:0] o, input logic [MW-1:0] a, input logic sa,
                      input logic [MW-1:0] b, input logic sb);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    op = o; mag_a = a; sign_a = sa; mag_b = b; sign_b = sb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = ~o; mag_a = ~a; mag_b = ~b; sign_a = ~sa; sign_b = ~sb;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    send(v.op, v.a, v.sa, v.b, v.sb);
    wait_out(lat);
    check({name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({name, "_res_hi"}, 64'(res_hi), 64'(v.exp_prod[2*MW-1:MW]));
    check({name, "_res_lo"}, 64'(res_lo), 64'(v.exp_prod[MW-1:0]));
    check({name, "_carry"}, 64'(carry), 64'(v.exp_carry));
    check({name, "_sign"}, 64'(sign_r), 64'(v.exp_sign));
    check({name, "_op_err"}, 64'(op_err), 64'(v.exp_err));
    finish_out(name);
  endtask

  initial begin
    int lat;
    logic [MW-1:0] bp_lo;
    logic          bp_err;

    vecs[0] = '{OP_ADD, 27'h4000000, 1'b0, 27'h4000000, 1'b0, 54'h0,  1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{OP_SUB, 27'd5,       1'b0, 27'd9,       1'b0, 54'd4,  1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{OP_ADD, 27'd7,       1'b1, 27'd7,       1'b0, 54'd0,  1'b0, 1'b0, 1'b0, 1};
    vecs[3] = '{OP_ADD, 27'd100,     1'b1, 27'd30,      1'b1, 54'd130, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{OP_SUB, 27'd100,     1'b1, 27'd30,      1'b1, 54'd70, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{OP_SUB, 27'h7FFFFFF, 1'b0, 27'h7FFFFFF, 1'b1, 54'h7FFFFFE, 1'b1, 1'b0, 1'b0, 1};
    vecs[6] = '{OP_ADD, 27'd5,       1'b1, 27'd0,       1'b0, 54'd5,  1'b0, 1'b1, 1'b0, 1};
    vecs[7] = '{OP_SUB, 27'd3,       1'b0, 27'd3,       1'b0, 54'd0,  1'b0, 1'b0, 1'b0, 1};
    vecs[8] = '{OP_RSV, 27'd12,      1'b0, 27'd5,       1'b1, 54'd0,  1'b0, 1'b0, 1'b1, 1};
`ifdef MANT_ALU_MUL_EN
    vecs[9]  = '{OP_MUL, 27'h7FFFFFF, 1'b0, 27'h7FFFFFF, 1'b1, 54'h3FFFFFF0000001, 1'b0, 1'b1, 1'b0, MUL_LAT};
    vecs[10] = '{OP_MUL, 27'd0,       1'b0, 27'd5,       1'b1, 54'd0,      1'b0, 1'b0, 1'b0, MUL_LAT};
    vecs[11] = '{OP_MUL, 27'h1234,    1'b0, 27'h100,     1'b1, 54'h123400, 1'b0, 1'b1, 1'b0, MUL_LAT};
    bp_lo  = 27'd12;
    bp_err = 1'b0;
`else
    vecs[9]  = '{OP_MUL, 27'h7FFFFFF, 1'b0, 27'h7FFFFFF, 1'b1, 54'd0, 1'b0, 1'b0, 1'b1, MUL_LAT};
    vecs[10] = '{OP_MUL, 27'd0,       1'b0, 27'd5,       1'b1, 54'd0, 1'b0, 1'b0, 1'b1, MUL_LAT};
    vecs[11] = '{OP_MUL, 27'h1234,    1'b0, 27'h100,     1'b1, 54'd0, 1'b0, 1'b0, 1'b1, MUL_LAT};
    bp_lo  = 27'd0;
    bp_err = 1'b1;
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = OP_ADD;
    mag_a = '0; mag_b = '0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'({res_hi, res_lo}), 64'd0);
    check("rst_flags", 64'({carry, sign_r, op_err}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held while out_ready is low; new bundles ignored.
    send(OP_MUL, 27'd3, 1'b0, 27'd4, 1'b0);
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'(MUL_LAT));
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = OP_ADD; mag_a = 27'(c + 1); mag_b = 27'd1;
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("bp_res%0d", c), 64'({res_hi, res_lo}), 64'(bp_lo));
      check($sformatf("bp_err%0d", c), 64'(op_err), 64'(bp_err));
    end
    in_valid = 1'b0;
    finish_out("bp");
    repeat (3) begin
      @(negedge clk);
      check("bp_no_spurious", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset in the middle of an operation.
`ifdef MANT_ALU_MUL_EN
    send(OP_MUL, 27'd100, 1'b0, 27'd200, 1'b1);
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(out_valid), 64'd0);
`else
    send(OP_ADD, 27'd9, 1'b0, 27'd4, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_held", 64'(out_valid), 64'd1);
`endif
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_res", 64'({res_hi, res_lo}), 64'd0);
    check("mid_rst_flags", 64'({carry, sign_r, op_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("post_rst_add", '{OP_ADD, 27'd1, 1'b0, 27'd2, 1'b0, 54'd3, 1'b0, 1'b0, 1'b0, 1});
`ifdef MANT_ALU_MUL_EN
    run_vec("post_rst_mul", '{OP_MUL, 27'd6, 1'b1, 27'd7, 1'b0, 54'd42, 1'b0, 1'b1, 1'b0, MUL_LAT});
`else
    run_vec("post_rst_mul", '{OP_MUL, 27'd6, 1'b1, 27'd7, 1'b0, 54'd0, 1'b0, 1'b0, 1'b1, MUL_LAT});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
